id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
ID/EX pipeline register of the LEGv8 5-stage core. It captures register-file read data, decoded control, immediate and register indices from the decode stage. It presents them to EX one cycle later. It detects load-use hazards against the instruction currently in EX and inserts bubbles. It supports downstream stall (hold) and branch flush.

Parameters:
DW, 64, datapath width; equals `WORD.
CTRL_W, 9, width of packed control bundle {Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}.
MEMREAD_BIT, 4, bit index of MemRead within ctrl.
REGWRITE_BIT, 5, bit index of RegWrite within ctrl.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  decode slot holds a real instruction
id_pc  input  DW  PC of decode instruction
id_r_reg1  input  5  source register 1 index
id_r_reg2  input  5  source register 2 index
id_w_reg  input  5  destination register index
id_r_data1  input  DW  register-file read data 1
id_r_data2  input  DW  register-file read data 2
id_imm  input  DW  sign-extended immediate
id_ctrl  input  CTRL_W  decoded control bundle
stall  input  1  downstream stall; hold all EX outputs
flush  input  1  branch taken; kill instruction entering EX
wb_reg  input  5  write-back destination (bypass only)
wb_data  input  DW  write-back data (bypass only)
wb_RegWrite  input  1  write-back enable (bypass only)
ld_use_hazard  output  1  combinational; upstream must hold PC and IF/ID this cycle
ex_valid  output  1  EX slot holds a real instruction
ex_pc  output  DW  registered PC
ex_r_reg1, ex_r_reg2, ex_w_reg  output  5 each  registered indices
ex_r_data1, ex_r_data2  output  DW each  registered operands
ex_imm  output  DW  registered immediate
ex_ctrl  output  CTRL_W  registered control; all-zero when ex_valid=0
bubble_cnt  output  16  count of bubbles inserted (load-use plus flush)

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs/registers are 0 immediately; bubble_cnt=0; ld_use_hazard follows from zeroed ex_ctrl and is 0.
- Load-use detection (combinational): ld_use_hazard=1 when all of the following hold:
  - ex_valid=1 and ex_ctrl[MEMREAD_BIT]=1;
  - ex_w_reg!=31;
  - id_valid=1;
  - ex_w_reg==id_r_reg1, or ex_w_reg==id_r_reg2.
  Otherwise 0. XZR (31) never creates a hazard.
- Per rising edge, with rst_n=1, priority is highest first:
  1. flush=1: load a bubble (ex_valid=0, ex_ctrl=0, datapath fields 0); bubble_cnt+1 if id_valid=1. Flush overrides stall.
  2. stall=1: hold every output register; bubble_cnt holds; ld_use_hazard is still evaluated on the held EX contents.
  3. ld_use_hazard=1: load a bubble; bubble_cnt+1. The decode instruction stays in ID (upstream holds) and is captured on the next edge.
  4. Otherwise: capture all id_* fields; ex_valid=id_valid; ex_ctrl=id_ctrl if id_valid else 0.
- Latency: exactly 1 cycle ID->EX when no stall, flush or hazard.
- A load-use bubble lasts exactly one cycle. After it the load has left EX, so the hazard deasserts (unless the new EX content is another matching load).
- bubble_cnt saturates at 16'hFFFF and does not wrap.
- Data fields of a bubble are zero; consumers qualify with ex_valid.
- The register file writes on the clock edge and reads combinationally, so same-cycle WB->ID data is stale unless the optional bypass is enabled.

Optional Feature:
WB_BYPASS_EN
- Defined: on a capture edge (case 4), if wb_RegWrite=1, wb_reg!=31 and wb_reg==id_r_reg1, then ex_r_data1 takes wb_data instead of id_r_data1. The same rule applies independently to reg2. Both may bypass in the same cycle.
- Not defined: ex_r_data1/2 always take id_r_data1/2; wb_* ports are present but unused.

Test Plan:
- Reset mid-operation: load pipeline with id_pc=0x40 and ADD ctrl, assert rst_n=0 between edges -> all ex_* and bubble_cnt read 0 immediately, before the next edge.
- Load-use: EX holds LDUR X9 (MemRead=1, ex_w_reg=9); ID presents ADD with id_r_reg2=9 -> ld_use_hazard=1; next edge ex_valid=0, ex_ctrl=0, bubble_cnt=1; following edge the ADD is captured with ex_valid=1.
- XZR exemption: EX LDUR with ex_w_reg=31; ID reads r_reg1=31 -> ld_use_hazard=0; ADD captured with no bubble.
- Stall vs flush: stall=1 for 3 cycles with id_pc changing -> ex_pc stays 0x100; then stall=1 and flush=1 together -> ex_valid=0, bubble_cnt increments by 1.
- Bypass (WB_BYPASS_EN defined): wb_RegWrite=1, wb_reg=5, wb_data=0xDEAD; id_r_reg1=5, id_r_data1=0x1 -> ex_r_data1=0xDEAD. Same stimulus with wb_reg=31 -> ex_r_data1=0x1. Macro undefined -> ex_r_data1=0x1 in both cases.
- Saturation: preload bubble_cnt=0xFFFE via 2 further load-use bubbles -> reads 0xFFFF and stays at 0xFFFF.

Source files
------------

// File: rtl/id_ex_pipe_if.sv
// Decode-to-execute bundle for id_ex_pipe: decode-side inputs, EX-side outputs, WB bypass taps.
// The master drives decode and control; the slave is the pipeline register.
interface id_ex_pipe_if #(
    parameter int unsigned DW     = 64,
    parameter int unsigned CTRL_W = 9
);
    logic              id_valid;
    logic [DW-1:0]     id_pc;
    logic [4:0]        id_r_reg1;
    logic [4:0]        id_r_reg2;
    logic [4:0]        id_w_reg;
    logic [DW-1:0]     id_r_data1;
    logic [DW-1:0]     id_r_data2;
    logic [DW-1:0]     id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              stall;
    logic              flush;
    logic [4:0]        wb_reg;
    logic [DW-1:0]     wb_data;
    logic              wb_RegWrite;

    logic              ld_use_hazard;
    logic              ex_valid;
    logic [DW-1:0]     ex_pc;
    logic [4:0]        ex_r_reg1;
    logic [4:0]        ex_r_reg2;
    logic [4:0]        ex_w_reg;
    logic [DW-1:0]     ex_r_data1;
    logic [DW-1:0]     ex_r_data2;
    logic [DW-1:0]     ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [15:0]       bubble_cnt;

    modport master (
        output id_valid, id_pc, id_r_reg1, id_r_reg2, id_w_reg, id_r_data1, id_r_data2,
               id_imm, id_ctrl, stall, flush, wb_reg, wb_data, wb_RegWrite,
        input  ld_use_hazard, ex_valid, ex_pc, ex_r_reg1, ex_r_reg2, ex_w_reg, ex_r_data1,
               ex_r_data2, ex_imm, ex_ctrl, bubble_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_r_reg1, id_r_reg2, id_w_reg, id_r_data1, id_r_data2,
               id_imm, id_ctrl, stall, flush, wb_reg, wb_data, wb_RegWrite,
        output ld_use_hazard, ex_valid, ex_pc, ex_r_reg1, ex_r_reg2, ex_w_reg, ex_r_data1,
               ex_r_data2, ex_imm, ex_ctrl, bubble_cnt
    );
endinterface

// File: rtl/id_ex_pipe.sv
// LEGv8 ID/EX pipeline register with load-use bubble insertion, stall hold and branch flush.
// Define WB_BYPASS_EN to forward same-cycle write-back data into the captured operands.
module id_ex_pipe #(
    parameter int unsigned DW           = 64,
    parameter int unsigned CTRL_W       = 9,
    parameter int unsigned MEMREAD_BIT  = 4,
    parameter int unsigned REGWRITE_BIT = 5
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_pipe_if.slave  bus
);
    localparam logic [4:0] Xzr = 5'd31;

    logic              r_valid, w_valid;
    logic [DW-1:0]     r_pc, w_pc;
    logic [4:0]        r_r_reg1, w_r_reg1;
    logic [4:0]        r_r_reg2, w_r_reg2;
    logic [4:0]        r_w_reg, w_w_reg;
    logic [DW-1:0]     r_r_data1, w_r_data1;
    logic [DW-1:0]     r_r_data2, w_r_data2;
    logic [DW-1:0]     r_imm, w_imm;
    logic [CTRL_W-1:0] r_ctrl, w_ctrl;
    logic [15:0]       r_bubble_cnt, w_bubble_cnt;
    logic [15:0]       w_cnt_inc;
    logic              w_hazard;
    logic [DW-1:0]     w_op1, w_op2;

    assign w_hazard = r_valid && r_ctrl[MEMREAD_BIT] && (r_w_reg != Xzr) && bus.id_valid &&
                      ((r_w_reg == bus.id_r_reg1) || (r_w_reg == bus.id_r_reg2));

    assign w_cnt_inc = (r_bubble_cnt == 16'hFFFF) ? r_bubble_cnt : r_bubble_cnt + 16'd1;

`ifdef WB_BYPASS_EN
    always_comb begin
        w_op1 = bus.id_r_data1;
        w_op2 = bus.id_r_data2;
        if (bus.wb_RegWrite && (bus.wb_reg != Xzr) && (bus.wb_reg == bus.id_r_reg1)) begin
            w_op1 = bus.wb_data;
        end
        if (bus.wb_RegWrite && (bus.wb_reg != Xzr) && (bus.wb_reg == bus.id_r_reg2)) begin
            w_op2 = bus.wb_data;
        end
    end
`else
    // Register file is read stale on a same-cycle write; the wb_* taps stay unused.
    assign w_op1 = bus.id_r_data1;
    assign w_op2 = bus.id_r_data2;
`endif

    always_comb begin
        w_valid      = r_valid;
        w_pc         = r_pc;
        w_r_reg1     = r_r_reg1;
        w_r_reg2     = r_r_reg2;
        w_w_reg      = r_w_reg;
        w_r_data1    = r_r_data1;
        w_r_data2    = r_r_data2;
        w_imm        = r_imm;
        w_ctrl       = r_ctrl;
        w_bubble_cnt = r_bubble_cnt;
        if (bus.flush || (!bus.stall && w_hazard)) begin
            w_valid   = 1'b0;
            w_pc      = '0;
            w_r_reg1  = '0;
            w_r_reg2  = '0;
            w_w_reg   = '0;
            w_r_data1 = '0;
            w_r_data2 = '0;
            w_imm     = '0;
            w_ctrl    = '0;
            // A flush only counts as a bubble when it kills a real instruction.
            if (!bus.flush || bus.id_valid) begin
                w_bubble_cnt = w_cnt_inc;
            end
        end else if (!bus.stall) begin
            w_valid   = bus.id_valid;
            w_pc      = bus.id_pc;
            w_r_reg1  = bus.id_r_reg1;
            w_r_reg2  = bus.id_r_reg2;
            w_w_reg   = bus.id_w_reg;
            w_r_data1 = w_op1;
            w_r_data2 = w_op2;
            w_imm     = bus.id_imm;
            w_ctrl    = bus.id_valid ? bus.id_ctrl : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_r_reg1     <= '0;
            r_r_reg2     <= '0;
            r_w_reg      <= '0;
            r_r_data1    <= '0;
            r_r_data2    <= '0;
            r_imm        <= '0;
            r_ctrl       <= '0;
            r_bubble_cnt <= '0;
        end else begin
            r_valid      <= w_valid;
            r_pc         <= w_pc;
            r_r_reg1     <= w_r_reg1;
            r_r_reg2     <= w_r_reg2;
            r_w_reg      <= w_w_reg;
            r_r_data1    <= w_r_data1;
            r_r_data2    <= w_r_data2;
            r_imm        <= w_imm;
            r_ctrl       <= w_ctrl;
            r_bubble_cnt <= w_bubble_cnt;
        end
    end

    assign bus.ld_use_hazard = w_hazard;
    assign bus.ex_valid      = r_valid;
    assign bus.ex_pc         = r_pc;
    assign bus.ex_r_reg1     = r_r_reg1;
    assign bus.ex_r_reg2     = r_r_reg2;
    assign bus.ex_w_reg      = r_w_reg;
    assign bus.ex_r_data1    = r_r_data1;
    assign bus.ex_r_data2    = r_r_data2;
    assign bus.ex_imm        = r_imm;
    assign bus.ex_ctrl       = r_ctrl;
    assign bus.bubble_cnt    = r_bubble_cnt;
endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed scenarios plus randomized traffic against a
// reference model of the EX slot; honours WB_BYPASS_EN the same way the design does.
module tb_id_ex_pipe;
    localparam int unsigned DW = 64;
    localparam logic [8:0] CtrlLdur = 9'b011110000;
    localparam logic [8:0] CtrlAdd  = 9'b000100010;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_pipe_if #(.DW(DW), .CTRL_W(9)) bus ();

    id_ex_pipe #(.DW(DW), .CTRL_W(9), .MEMREAD_BIT(4), .REGWRITE_BIT(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference view of the EX slot
    logic          m_valid;
    logic [DW-1:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]    m_r1, m_r2, m_w;
    logic [8:0]    m_ctrl;
    int            m_cnt;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0; m_pc = '0; m_d1 = '0; m_d2 = '0; m_imm = '0;
        m_r1 = '0; m_r2 = '0; m_w = '0; m_ctrl = '0;
    endtask

    function automatic logic model_haz();
        return m_valid && m_ctrl[4] && m_w != 5'd31 && bus.id_valid &&
               (m_w == bus.id_r_reg1 || m_w == bus.id_r_reg2);
    endfunction

    function automatic logic [DW-1:0] operand(input logic [4:0] rs, input logic [DW-1:0] rf);
`ifdef WB_BYPASS_EN
        if (bus.wb_RegWrite && bus.wb_reg != 5'd31 && bus.wb_reg == rs) return bus.wb_data;
`endif
        return rf;
    endfunction

    task automatic model_edge(input logic haz, input logic [DW-1:0] op1,
                              input logic [DW-1:0] op2);
        if (bus.flush) begin
            model_clear();
            if (bus.id_valid && m_cnt < 65535) m_cnt++;
        end else if (bus.stall) begin
            // held
        end else if (haz) begin
            model_clear();
            if (m_cnt < 65535) m_cnt++;
        end else begin
            m_valid = bus.id_valid; m_pc = bus.id_pc; m_r1 = bus.id_r_reg1;
            m_r2 = bus.id_r_reg2; m_w = bus.id_w_reg; m_d1 = op1; m_d2 = op2;
            m_imm = bus.id_imm; m_ctrl = bus.id_valid ? bus.id_ctrl : 9'd0;
        end
    endtask

    task automatic check_outputs();
        chk("ex_valid", {63'd0, bus.ex_valid}, {63'd0, m_valid});
        chk("ex_pc", bus.ex_pc, m_pc);
        chk("ex_r_reg1", {59'd0, bus.ex_r_reg1}, {59'd0, m_r1});
        chk("ex_r_reg2", {59'd0, bus.ex_r_reg2}, {59'd0, m_r2});
        chk("ex_w_reg", {59'd0, bus.ex_w_reg}, {59'd0, m_w});
        chk("ex_r_data1", bus.ex_r_data1, m_d1);
        chk("ex_r_data2", bus.ex_r_data2, m_d2);
        chk("ex_imm", bus.ex_imm, m_imm);
        chk("ex_ctrl", {55'd0, bus.ex_ctrl}, {55'd0, m_ctrl});
        chk("bubble_cnt", {48'd0, bus.bubble_cnt}, 64'(m_cnt));
    endtask

    // Inputs are already driven; check the hazard, clock once, then check EX.
    task automatic cycle(input logic full = 1'b1);
        logic haz;
        logic [DW-1:0] op1, op2;
        #1;
        haz = model_haz();
        op1 = operand(bus.id_r_reg1, bus.id_r_data1);
        op2 = operand(bus.id_r_reg2, bus.id_r_data2);
        chk("ld_use_hazard", {63'd0, bus.ld_use_hazard}, {63'd0, haz});
        @(posedge clk);
        model_edge(haz, op1, op2);
        #1;
        if (full) check_outputs();
        else chk("bubble_cnt_fast", {48'd0, bus.bubble_cnt}, 64'(m_cnt));
    endtask

    task automatic drive_id(input logic v, input logic [DW-1:0] pc, input logic [4:0] r1,
                            input logic [4:0] r2, input logic [4:0] w, input logic [8:0] c);
        bus.id_valid = v; bus.id_pc = pc; bus.id_r_reg1 = r1; bus.id_r_reg2 = r2;
        bus.id_w_reg = w; bus.id_ctrl = c;
        bus.id_r_data1 = 64'h1000 + 64'(r1); bus.id_r_data2 = 64'h2000 + 64'(r2);
        bus.id_imm = pc ^ 64'h5A;
    endtask

    initial begin
        int saved;
        logic [DW-1:0] exp_byp;
        bus.stall = 0; bus.flush = 0; bus.wb_reg = 0; bus.wb_data = 0; bus.wb_RegWrite = 0;
        drive_id(1'b0, '0, '0, '0, '0, '0);
        model_clear();
        m_cnt = 0;

        // Power-on reset
        #2;
        check_outputs();
        chk("rst_hazard", {63'd0, bus.ld_use_hazard}, 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-operation
        drive_id(1'b1, 64'h40, 5'd1, 5'd2, 5'd3, CtrlAdd);
        cycle();
        chk("pre_rst_pc", bus.ex_pc, 64'h40);
        #1 rst_n = 1'b0;
        #1;
        model_clear();
        m_cnt = 0;
        check_outputs();
        chk("mid_rst_pc", bus.ex_pc, 64'd0);
        rst_n = 1'b1;

        // Load-use: LDUR X9 then ADD reading X9 as reg2
        drive_id(1'b1, 64'h80, 5'd1, 5'd2, 5'd9, CtrlLdur);
        cycle();
        drive_id(1'b1, 64'h84, 5'd3, 5'd9, 5'd4, CtrlAdd);
        #1;
        chk("lu_hazard", {63'd0, bus.ld_use_hazard}, 64'd1);
        cycle();
        chk("lu_bubble_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("lu_bubble_ctrl", {55'd0, bus.ex_ctrl}, 64'd0);
        chk("lu_bubble_cnt", {48'd0, bus.bubble_cnt}, 64'd1);
        cycle();
        chk("lu_add_valid", {63'd0, bus.ex_valid}, 64'd1);
        chk("lu_add_pc", bus.ex_pc, 64'h84);

        // XZR exemption
        drive_id(1'b1, 64'h90, 5'd1, 5'd2, 5'd31, CtrlLdur);
        cycle();
        saved = m_cnt;
        drive_id(1'b1, 64'h94, 5'd31, 5'd2, 5'd5, CtrlAdd);
        #1;
        chk("xzr_hazard", {63'd0, bus.ld_use_hazard}, 64'd0);
        cycle();
        chk("xzr_add_ctrl", {55'd0, bus.ex_ctrl}, {55'd0, CtrlAdd});
        chk("xzr_cnt", {48'd0, bus.bubble_cnt}, 64'(saved));

        // Stall holds, flush overrides stall
        drive_id(1'b1, 64'h100, 5'd1, 5'd2, 5'd6, CtrlAdd);
        cycle();
        saved = m_cnt;
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_id(1'b1, 64'h104 + 64'(4 * i), 5'd7, 5'd8, 5'd9, CtrlLdur);
            cycle();
            chk("stall_pc", bus.ex_pc, 64'h100);
        end
        bus.flush = 1'b1;
        cycle();
        chk("flush_valid", {63'd0, bus.ex_valid}, 64'd0);
        chk("flush_cnt", {48'd0, bus.bubble_cnt}, 64'(saved + 1));
        bus.stall = 1'b0; bus.flush = 1'b0;

        // Write-back bypass
        drive_id(1'b1, 64'h200, 5'd5, 5'd2, 5'd6, CtrlAdd);
        bus.id_r_data1 = 64'h1;
        bus.wb_RegWrite = 1'b1; bus.wb_reg = 5'd5; bus.wb_data = 64'hDEAD;
`ifdef WB_BYPASS_EN
        exp_byp = 64'hDEAD;
`else
        exp_byp = 64'h1;
`endif
        cycle();
        chk("bypass_r5", bus.ex_r_data1, exp_byp);
        bus.wb_reg = 5'd31;
        cycle();
        chk("bypass_xzr", bus.ex_r_data1, 64'h1);
        bus.wb_RegWrite = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_id(1'($urandom), {$urandom, $urandom},
                     ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
                     ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
                     ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
                     ($urandom_range(0, 2) == 0) ? CtrlLdur : 9'($urandom));
            bus.id_r_data1 = {$urandom, $urandom};
            bus.id_r_data2 = {$urandom, $urandom};
            bus.stall = ($urandom_range(0, 7) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.wb_RegWrite = 1'($urandom);
            bus.wb_reg = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
            bus.wb_data = {$urandom, $urandom};
            cycle();
        end
        bus.stall = 1'b0; bus.flush = 1'b0; bus.wb_RegWrite = 1'b0;

        // Saturation: flush up to 0xFFFE, then two load-use bubbles
        drive_id(1'b1, 64'h300, 5'd9, 5'd9, 5'd9, CtrlLdur);
        bus.flush = 1'b1;
        while (m_cnt < 16'hFFFE) cycle(1'b0);
        bus.flush = 1'b0;
        chk("sat_preload", {48'd0, bus.bubble_cnt}, 64'hFFFE);
        for (int i = 0; i < 4; i++) cycle();
        chk("sat_hold", {48'd0, bus.bubble_cnt}, 64'hFFFF);
        cycle();
        chk("sat_stay", {48'd0, bus.bubble_cnt}, 64'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
